// File: rtl/xif_copro_pkg.sv
// ============================================================================
// xif_copro_pkg : shared types for the core-side XIF offload unit
// Revision      : 1.0
// ============================================================================
`default_nettype none

package xif_copro_pkg;

  localparam int C_XLEN            = 32;
  localparam int C_X_NUM_RS        = 2;
  localparam int C_X_ID_WIDTH      = 4;
  localparam int C_MAX_OUTSTANDING = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    COMMIT = 2'd2
  } offload_state_e;

  typedef struct packed {
    logic [31:0]                    instr;
    logic [1:0]                     mode;
    logic [C_X_NUM_RS*C_XLEN-1:0]   rs;
    logic [C_X_NUM_RS-1:0]          rs_valid;
    logic [C_X_ID_WIDTH-1:0]        id;
  } offload_req_t;

  // IDs wrap modulo 2**C_X_ID_WIDTH through natural truncation.
  function automatic logic [C_X_ID_WIDTH-1:0] next_id_f(input logic [C_X_ID_WIDTH-1:0] id);
    return id + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/xif_copro_scoreboard.sv
// ============================================================================
// xif_copro_scoreboard : per-ID outstanding bits with occupancy count
// Revision             : 1.0
// ============================================================================
`default_nettype none

module xif_copro_scoreboard #(
  parameter int ID_WIDTH = 4,
  parameter int MAX_OUT  = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           i_set,
  input  logic [ID_WIDTH-1:0]            i_set_id,
  input  logic                           i_clr,
  input  logic [ID_WIDTH-1:0]            i_clr_id,
  input  logic [ID_WIDTH-1:0]            i_query_a,
  output logic                           o_hit_a,
  input  logic [ID_WIDTH-1:0]            i_query_b,
  output logic                           o_hit_b,
  output logic [$clog2(MAX_OUT+1)-1:0]   o_count
);

  localparam int DEPTH = 2**ID_WIDTH;

  logic [DEPTH-1:0]             r_bits;
  logic [DEPTH-1:0]             w_set_mask;
  logic [DEPTH-1:0]             w_clr_mask;
  logic [$clog2(MAX_OUT+1)-1:0] r_count;

  always_comb begin
    w_set_mask           = '0;
    w_clr_mask           = '0;
    w_set_mask[i_set_id] = i_set;
    w_clr_mask[i_clr_id] = i_clr;
  end

  // Set and clear never target the same ID, so simultaneous events cancel in the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bits  <= '0;
      r_count <= '0;
    end else begin
      r_bits <= (r_bits | w_set_mask) & ~w_clr_mask;
      case ({i_set, i_clr})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_hit_a = r_bits[i_query_a];
  assign o_hit_b = r_bits[i_query_b];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/xif_copro_offload_unit.sv
// ============================================================================
// xif_copro_offload_unit : core-side XIF issue/commit/result initiator
// Revision               : 1.0
// ============================================================================
`default_nettype none

module xif_copro_offload_unit
  import xif_copro_pkg::*;
#(
  parameter int XLEN            = C_XLEN,
  parameter int X_NUM_RS        = C_X_NUM_RS,
  parameter int X_ID_WIDTH      = C_X_ID_WIDTH,
  parameter int MAX_OUTSTANDING = C_MAX_OUTSTANDING
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       instr_valid_i,
  output logic                       instr_ready_o,
  input  logic [31:0]                instr_i,
  input  logic [1:0]                 mode_i,
  input  logic [X_NUM_RS*XLEN-1:0]   rs_i,
  input  logic [X_NUM_RS-1:0]        rs_valid_i,
  input  logic                       kill_i,
  output logic                       instr_done_o,
  output logic                       instr_accept_o,
  output logic                       issue_valid_o,
  input  logic                       issue_ready_i,
  output logic [31:0]                issue_instr_o,
  output logic [1:0]                 issue_mode_o,
  output logic [X_ID_WIDTH-1:0]      issue_id_o,
  output logic [X_NUM_RS*XLEN-1:0]   issue_rs_o,
  output logic [X_NUM_RS-1:0]        issue_rs_valid_o,
  input  logic                       issue_accept_i,
  input  logic                       issue_writeback_i,
  output logic                       commit_valid_o,
  output logic [X_ID_WIDTH-1:0]      commit_id_o,
  output logic                       commit_kill_o,
  input  logic                       result_valid_i,
  output logic                       result_ready_o,
  input  logic [X_ID_WIDTH-1:0]      result_id_i,
  input  logic [4:0]                 result_rd_i,
  input  logic [XLEN-1:0]            result_data_i,
  input  logic                       result_we_i,
  output logic                       wb_valid_o,
  output logic [4:0]                 wb_addr_o,
  output logic [XLEN-1:0]            wb_data_o,
  output logic                       busy_o,
  output logic                       spurious_o
);

  localparam int              CW        = $clog2(MAX_OUTSTANDING+1);
  localparam logic [CW-1:0]   C_MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [1:0]      S_IDLE    = IDLE;
  localparam logic [1:0]      S_ISSUE   = ISSUE;
  localparam logic [1:0]      S_COMMIT  = COMMIT;

  logic [1:0]            r_state;
  offload_req_t          r_req;
  logic                  r_issue_wb;
  logic [X_ID_WIDTH-1:0] r_next_id;
  logic                  r_active;
  logic                  r_spurious;
  logic                  r_wb_valid;
  logic [4:0]            r_wb_addr;
  logic [XLEN-1:0]       r_wb_data;

  logic                  w_instr_hs;
  logic                  w_commit_set;
  logic                  w_res_hs;
  logic                  w_hit_next;
  logic                  w_hit_res;
  logic [CW-1:0]         w_count;

  // r_active holds the handshake outputs low while in reset.
  assign instr_ready_o  = r_active & (r_state == S_IDLE) & instr_valid_i &
                          (w_count < C_MAX_CNT) & ~w_hit_next;
  assign w_instr_hs     = instr_ready_o;
  assign issue_valid_o  = (r_state == S_ISSUE);
  assign instr_done_o   = issue_valid_o & issue_ready_i;
  assign instr_accept_o = instr_done_o & issue_accept_i;
  assign commit_valid_o = (r_state == S_COMMIT);
  assign commit_kill_o  = commit_valid_o & kill_i;
  assign w_commit_set   = commit_valid_o & ~kill_i & r_issue_wb;
  assign w_res_hs       = result_valid_i & r_active;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_req      <= '0;
      r_issue_wb <= 1'b0;
      r_next_id  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_instr_hs) begin
            r_req.instr    <= instr_i;
            r_req.mode     <= mode_i;
            r_req.rs       <= rs_i;
            r_req.rs_valid <= rs_valid_i;
            r_req.id       <= r_next_id;
            r_state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue_ready_i) begin
            r_issue_wb <= issue_writeback_i;
            r_state    <= issue_accept_i ? S_COMMIT : S_IDLE;
          end
        end
        S_COMMIT: begin
          // The ID is consumed even when killed; a rejected issue leaves it for reuse.
          r_next_id <= next_id_f(r_next_id);
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_active   <= 1'b0;
      r_spurious <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else begin
      r_active   <= 1'b1;
      r_wb_valid <= w_res_hs & w_hit_res & result_we_i & (result_rd_i != 5'd0);
      if (w_res_hs & w_hit_res) begin
        r_wb_addr <= result_rd_i;
        r_wb_data <= result_data_i;
      end
      if (w_res_hs & ~w_hit_res) begin
        r_spurious <= 1'b1;
      end
    end
  end

  xif_copro_scoreboard #(
    .ID_WIDTH (X_ID_WIDTH),
    .MAX_OUT  (MAX_OUTSTANDING)
  ) u_scoreboard (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .i_set     (w_commit_set),
    .i_set_id  (r_req.id),
    .i_clr     (w_res_hs & w_hit_res),
    .i_clr_id  (result_id_i),
    .i_query_a (r_next_id),
    .o_hit_a   (w_hit_next),
    .i_query_b (result_id_i),
    .o_hit_b   (w_hit_res),
    .o_count   (w_count)
  );

  assign issue_instr_o    = r_req.instr;
  assign issue_mode_o     = r_req.mode;
  assign issue_id_o       = r_req.id;
  assign issue_rs_o       = r_req.rs;
  assign issue_rs_valid_o = r_req.rs_valid;
  assign commit_id_o      = r_req.id;
  assign result_ready_o   = r_active;
  assign wb_valid_o       = r_wb_valid;
  assign wb_addr_o        = r_wb_addr;
  assign wb_data_o        = r_wb_data;
  assign spurious_o       = r_spurious;
  assign busy_o           = (w_count != '0) | (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_xif_copro_offload_unit.sv
// ============================================================================
// tb_xif_copro_offload_unit : randomized scoreboard bench for the offload unit
// Revision                  : 1.0
// ============================================================================
`default_nettype none

module tb_xif_copro_offload_unit;

  localparam int NID = 16;
  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid_i = 1'b0, instr_ready_o;
  logic [31:0] instr_i = '0;
  logic [1:0]  mode_i = '0;
  logic [63:0] rs_i = '0;
  logic [1:0]  rs_valid_i = '0;
  logic        kill_i = 1'b0;
  logic        instr_done_o, instr_accept_o, issue_valid_o;
  logic        issue_ready_i = 1'b0;
  logic [31:0] issue_instr_o;
  logic [1:0]  issue_mode_o;
  logic [3:0]  issue_id_o;
  logic [63:0] issue_rs_o;
  logic [1:0]  issue_rs_valid_o;
  logic        issue_accept_i = 1'b0, issue_writeback_i = 1'b0;
  logic        commit_valid_o, commit_kill_o;
  logic [3:0]  commit_id_o;
  logic        result_valid_i = 1'b0, result_ready_o;
  logic [3:0]  result_id_i = '0;
  logic [4:0]  result_rd_i = '0;
  logic [31:0] result_data_i = '0;
  logic        result_we_i = 1'b0;
  logic        wb_valid_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;
  logic        busy_o, spurious_o;

  always #5 clk = ~clk;

  xif_copro_offload_unit dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
    .mode_i(mode_i), .rs_i(rs_i), .rs_valid_i(rs_valid_i), .kill_i(kill_i),
    .instr_done_o(instr_done_o), .instr_accept_o(instr_accept_o),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_instr_o(issue_instr_o), .issue_mode_o(issue_mode_o), .issue_id_o(issue_id_o),
    .issue_rs_o(issue_rs_o), .issue_rs_valid_o(issue_rs_valid_o),
    .issue_accept_i(issue_accept_i), .issue_writeback_i(issue_writeback_i),
    .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .commit_kill_o(commit_kill_o),
    .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
    .result_id_i(result_id_i), .result_rd_i(result_rd_i), .result_data_i(result_data_i),
    .result_we_i(result_we_i),
    .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .busy_o(busy_o), .spurious_o(spurious_o)
  );

  typedef struct { int id; bit kill; } commit_t;
  typedef struct { int addr; logic [31:0] data; } wb_t;

  commit_t commit_q[$];
  wb_t     wb_q[$];
  commit_t mon_c;
  wb_t     mon_w;

  // Reference model: set of outstanding IDs, next ID counter, sticky spurious flag.
  bit outstanding[NID];
  int next_id = 0;
  bit exp_spur = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int n_out();
    int n = 0;
    for (int i = 0; i < NID; i++) n += int'(outstanding[i]);
    return n;
  endfunction

  function automatic bit exp_ready();
    return (n_out() < MAXO) && !outstanding[next_id];
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (commit_valid_o) begin
        if (commit_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_commit: got id %0d expected none", commit_id_o);
        end else begin
          mon_c = commit_q.pop_front();
          chk("commit_id", 64'(commit_id_o), 64'(mon_c.id));
          chk("commit_kill", 64'(commit_kill_o), 64'(mon_c.kill));
        end
      end
      if (wb_valid_o) begin
        if (wb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb: got addr %0d expected none", wb_addr_o);
        end else begin
          mon_w = wb_q.pop_front();
          chk("wb_addr", 64'(wb_addr_o), 64'(mon_w.addr));
          chk("wb_data", 64'(wb_data_o), 64'(mon_w.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offload(input bit acc, input bit wb, input bit kill, input int dly);
    logic [31:0] ins;
    logic [1:0]  md;
    logic [63:0] rs;
    logic [1:0]  rsv;
    int budget;
    int id;
    ins = $urandom; md = 2'($urandom_range(0, 3));
    rs = {$urandom, $urandom}; rsv = 2'($urandom_range(0, 3));
    instr_valid_i = 1'b1; instr_i = ins; mode_i = md; rs_i = rs; rs_valid_i = rsv;
    budget = 50;
    #1;
    while (!instr_ready_o && budget > 0) begin
      @(posedge clk); #2; budget--;
    end
    if (budget == 0) begin
      chk("instr_ready_timeout", 64'(instr_ready_o), 64'd1);
      instr_valid_i = 1'b0;
      return;
    end
    tick();
    instr_valid_i = 1'b0;
    id = next_id;
    chk("issue_valid", 64'(issue_valid_o), 64'd1);
    chk("issue_id", 64'(issue_id_o), 64'(id));
    chk("issue_instr", 64'(issue_instr_o), 64'(ins));
    chk("issue_mode", 64'(issue_mode_o), 64'(md));
    chk("issue_rs", issue_rs_o, rs);
    chk("issue_rs_valid", 64'(issue_rs_valid_o), 64'(rsv));
    for (int k = 0; k < dly; k++) begin
      chk("done_while_stalled", 64'(instr_done_o), 64'd0);
      tick();
      chk("issue_valid_held", 64'(issue_valid_o), 64'd1);
      chk("issue_instr_held", 64'(issue_instr_o), 64'(ins));
      chk("issue_rs_held", issue_rs_o, rs);
      chk("issue_id_held", 64'(issue_id_o), 64'(id));
    end
    issue_ready_i = 1'b1; issue_accept_i = acc; issue_writeback_i = wb;
    #1;
    chk("instr_done", 64'(instr_done_o), 64'd1);
    chk("instr_accept", 64'(instr_accept_o), 64'(acc));
    if (acc) begin
      commit_q.push_back('{id, kill});
      if (!kill && wb) outstanding[id] = 1'b1;
      next_id = (next_id + 1) % NID;
    end
    @(posedge clk); #1;
    issue_ready_i = 1'b0; issue_accept_i = 1'b0; issue_writeback_i = 1'b0;
    if (acc) begin
      kill_i = kill;
      tick();
      kill_i = 1'b0;
    end
  endtask

  task automatic result(input int id, input int rd, input logic [31:0] data, input bit we);
    result_valid_i = 1'b1; result_id_i = 4'(id); result_rd_i = 5'(rd);
    result_data_i = data; result_we_i = we;
    #1;
    chk("result_ready", 64'(result_ready_o), 64'd1);
    if (outstanding[id]) begin
      outstanding[id] = 1'b0;
      if (we && rd != 0) wb_q.push_back('{rd, data});
    end else begin
      exp_spur = 1'b1;
    end
    tick();
    result_valid_i = 1'b0;
    chk("spurious", 64'(spurious_o), 64'(exp_spur));
  endtask

  task automatic drain_one();
    int start = $urandom_range(0, NID - 1);
    for (int i = 0; i < NID; i++) begin
      if (outstanding[(start + i) % NID]) begin
        result((start + i) % NID, $urandom_range(0, 31), $urandom, $urandom_range(0, 3) != 0);
        return;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int id;
    instr_valid_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result_ready", 64'(result_ready_o), 64'd0);
    chk("rst_instr_ready", 64'(instr_ready_o), 64'd0);
    chk("rst_issue_valid", 64'(issue_valid_o), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    instr_valid_i = 1'b0;
    rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_result_ready", 64'(result_ready_o), 64'd1);
    chk("post_rst_spurious", 64'(spurious_o), 64'd0);

    // Rejected issue leaves id0 for the next instruction.
    offload(1'b0, 1'b1, 1'b0, 0);
    offload(1'b1, 1'b1, 1'b0, 0);
    result(0, 5, 32'hDEADBEEF, 1'b1);

    offload(1'b1, 1'b1, 1'b0, 3);
    result(1, $urandom_range(1, 31), $urandom, 1'b1);

    // Fill to MAX_OUTSTANDING, confirm stall, release with id2.
    for (int i = 0; i < MAXO; i++) offload(1'b1, 1'b1, 1'b0, $urandom_range(0, 1));
    chk("busy_full", 64'(busy_o), 64'd1);
    instr_valid_i = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", 64'(instr_ready_o), 64'(exp_ready()));
      tick();
    end
    instr_valid_i = 1'b0;
    result(2, $urandom_range(1, 31), $urandom, 1'b1);
    offload(1'b1, 1'b1, 1'b0, 0);
    result(6, $urandom_range(0, 31), $urandom, 1'b1);
    result(3, $urandom_range(0, 31), $urandom, 1'b1);
    result(5, $urandom_range(0, 31), $urandom, 1'b1);
    result(4, $urandom_range(0, 31), $urandom, 1'b1);

    // Killed commit never enters the scoreboard.
    offload(1'b1, 1'b1, 1'b1, 0);
    chk("busy_after_kill", 64'(busy_o), 64'(n_out() != 0));
    result(7, 9, $urandom, 1'b1);

    for (int i = 0; i < 17; i++) begin
      id = next_id;
      offload(1'b1, 1'b1, 1'b0, $urandom_range(0, 2));
      result(id, $urandom_range(0, 31), $urandom, $urandom_range(0, 3) != 0);
    end

    for (int i = 0; i < 40; i++) begin
      while (n_out() >= MAXO || outstanding[next_id]) drain_one();
      offload($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 2));
      if ($urandom_range(0, 1) != 0) drain_one();
      if ($urandom_range(0, 7) == 0) result($urandom_range(0, NID - 1), 3, $urandom, 1'b1);
    end
    while (n_out() != 0) drain_one();

    // Reset in the middle of an issue discards it.
    instr_valid_i = 1'b1;
    #1;
    chk("pre_rst_ready", 64'(instr_ready_o), 64'd1);
    tick();
    instr_valid_i = 1'b0;
    chk("pre_rst_issue_valid", 64'(issue_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_issue_valid", 64'(issue_valid_o), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    tick();
    rst_n = 1'b1;
    next_id = 0;
    exp_spur = 1'b0;
    for (int i = 0; i < NID; i++) outstanding[i] = 1'b0;
    tick(); tick();
    offload(1'b1, 1'b1, 1'b0, 1);
    result(0, 17, $urandom, 1'b1);

    repeat (3) tick();
    chk("commit_q_empty", 64'(commit_q.size()), 64'd0);
    chk("wb_q_empty", 64'(wb_q.size()), 64'd0);
    chk("final_busy", 64'(busy_o), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
